// File: rtl/multdiv_stall_controller.sv
// multdiv_stall_controller
// Sequences the multi-cycle multiplier/divider for R-type mul/div in DX:
// freezes PC/FD/DX, bubbles XM while the unit works, then hands the result
// (or the rstatus exception code) to XM for exactly one cycle.
// Optional build macro: MD_WATCHDOG_EN (BUSY timeout after MD_TIMEOUT cycles).
module multdiv_stall_controller #(
  parameter int MD_TIMEOUT  = 48,
  parameter int RSTATUS_REG = 30
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] DX_Latch_Instr,
  input  logic        DX_valid,
  input  logic        flush,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        md_bubble,
  output logic        md_wb_valid,
  output logic [31:0] md_wb_data,
  output logic [4:0]  md_wb_rd,
  output logic [5:0]  md_cycles
);

`ifdef MD_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [5:0]  TIMEOUT_C = 6'(MD_TIMEOUT);
  localparam logic [4:0]  RSTATUS_C = 5'(RSTATUS_REG);
  localparam logic [31:0] EXC_MUL   = 32'd4;
  localparam logic [31:0] EXC_DIV   = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state;
  logic        op_div_q;
  logic [4:0]  rd_q;
  logic [31:0] res_q;
  logic        exc_q;

  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [4:0]  instr_rd;
  logic        is_mul;
  logic        is_div;
  logic        start_req;
  logic [5:0]  cyc_next;
  logic        wd_fire;
  logic        unused_instr_bits;

  assign opcode    = DX_Latch_Instr[31:27];
  assign instr_rd  = DX_Latch_Instr[26:22];
  assign alu_op    = DX_Latch_Instr[6:2];
  assign unused_instr_bits = ^{DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

  assign is_mul    = DX_valid && (opcode == 5'd0) && (alu_op == 5'd6);
  assign is_div    = DX_valid && (opcode == 5'd0) && (alu_op == 5'd7);
  assign start_req = (is_mul || is_div) && !flush;

  assign cyc_next  = (md_cycles == 6'd63) ? 6'd63 : md_cycles + 6'd1;
  // Compile-time constant gate: without the watchdog this folds to 0.
  assign wd_fire   = WD_EN && (cyc_next >= TIMEOUT_C);

  // Sequencer: state, latched op/rd, result holding registers, cycle counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_div_q  <= 1'b0;
      rd_q      <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      md_cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req) begin
            state     <= S_START;
            op_div_q  <= is_div;
            rd_q      <= instr_rd;
            md_cycles <= '0;
          end
        end
        S_START: begin
          state <= flush ? S_IDLE : S_BUSY;
        end
        S_BUSY: begin
          md_cycles <= cyc_next;
          if (flush) begin
            state <= S_IDLE;
          end else if (md_result_rdy) begin
            state <= S_DONE;
            res_q <= md_result;
            exc_q <= md_exception;
          end else if (wd_fire) begin
            state <= S_DONE;
            res_q <= '0;
            exc_q <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pipeline control: IDLE stalls combinationally on the detect cycle
  assign stall       = (state == S_START) || (state == S_BUSY) ||
                       ((state == S_IDLE) && start_req);
  assign md_bubble   = stall;
  assign ctrl_MULT   = (state == S_START) && !op_div_q;
  assign ctrl_DIV    = (state == S_START) && op_div_q;
  assign md_wb_valid = (state == S_DONE);

  // Writeback payload, only non-zero during the DONE cycle
  always_comb begin
    md_wb_data = '0;
    md_wb_rd   = '0;
    if (state == S_DONE) begin
      if (exc_q) begin
        md_wb_data = op_div_q ? EXC_DIV : EXC_MUL;
        md_wb_rd   = RSTATUS_C;
      end else begin
        md_wb_data = res_q;
        md_wb_rd   = rd_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// Bench for multdiv_stall_controller: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_multdiv_stall_controller;

  localparam int MD_TIMEOUT  = 48;
  localparam int RSTATUS_REG = 30;
  localparam logic [31:0] MUL_R3 = 32'h00C22018;
  localparam logic [31:0] DIV_R4 = 32'h010A601C;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] DX_Latch_Instr;
  logic        DX_valid;
  logic        flush;
  logic        md_result_rdy;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        md_bubble;
  logic        md_wb_valid;
  logic [31:0] md_wb_data;
  logic [4:0]  md_wb_rd;
  logic [5:0]  md_cycles;

  always #5 clock = ~clock;

  multdiv_stall_controller #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .RSTATUS_REG(RSTATUS_REG)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .DX_Latch_Instr(DX_Latch_Instr),
    .DX_valid      (DX_valid),
    .flush         (flush),
    .md_result_rdy (md_result_rdy),
    .md_exception  (md_exception),
    .md_result     (md_result),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .stall         (stall),
    .md_bubble     (md_bubble),
    .md_wb_valid   (md_wb_valid),
    .md_wb_data    (md_wb_data),
    .md_wb_rd      (md_wb_rd),
    .md_cycles     (md_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Transaction model: an op in flight is described by its position in the
  // sequence (1 = start-pulse cycle, 2.. = waiting cycles) and a done flag.
  bit          m_active = 0;
  bit          m_done   = 0;
  int          m_pos    = 0;
  bit          m_div    = 0;
  logic [4:0]  m_rd     = '0;
  logic [31:0] m_res    = '0;
  bit          m_exc    = 0;
  int          m_cyc    = 0;

  // DUT outputs as sampled on the last falling edge
  logic        s_stall, s_mult, s_div, s_valid;
  logic [31:0] s_data;
  logic [4:0]  s_rd;
  logic [5:0]  s_cyc;

`ifdef MD_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit dec_kind(input logic [31:0] i, input logic v, input int alu);
    return v && (i[31:27] == 5'd0) && (int'(i[6:2]) == alu);
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [4:0] alu);
    logic [31:0] v;
    v        = $urandom;
    v[31:27] = 5'd0;
    v[26:22] = rd;
    v[6:2]   = alu;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_pos = 0; m_cyc = 0;
    m_res = '0; m_exc = 0; m_rd = '0; m_div = 0;
  endtask

  task automatic model_step();
    bit mul_i, div_i;
    mul_i = dec_kind(DX_Latch_Instr, DX_valid, 6);
    div_i = dec_kind(DX_Latch_Instr, DX_valid, 7);
    if (m_done) begin
      m_done = 0; m_active = 0;
    end else if (m_active) begin
      if (m_pos >= 2) m_cyc = (m_cyc < 63) ? m_cyc + 1 : 63;
      if (flush) m_active = 0;
      else if (m_pos >= 2) begin
        if (md_result_rdy) begin
          m_done = 1; m_res = md_result; m_exc = md_exception;
        end else if (WD && m_cyc >= MD_TIMEOUT) begin
          m_done = 1; m_res = '0; m_exc = 1;
        end
      end
      m_pos++;
    end else if ((mul_i || div_i) && !flush) begin
      m_active = 1; m_pos = 1; m_div = div_i;
      m_rd = DX_Latch_Instr[26:22]; m_cyc = 0;
    end
  endtask

  task automatic compare_all();
    logic e_mult, e_div, e_stall, e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    e_mult = 0; e_div = 0; e_stall = 0; e_valid = 0; e_data = '0; e_rd = '0;
    if (m_done) begin
      e_valid = 1;
      e_data  = m_exc ? (m_div ? 32'd5 : 32'd4) : m_res;
      e_rd    = m_exc ? 5'(RSTATUS_REG) : m_rd;
    end else if (m_active) begin
      e_stall = 1;
      if (m_pos == 1) begin e_mult = !m_div; e_div = m_div; end
    end else begin
      e_stall = (dec_kind(DX_Latch_Instr, DX_valid, 6) ||
                 dec_kind(DX_Latch_Instr, DX_valid, 7)) && !flush;
    end
    chk("ctrl_MULT",   32'(ctrl_MULT),   32'(e_mult));
    chk("ctrl_DIV",    32'(ctrl_DIV),    32'(e_div));
    chk("stall",       32'(stall),       32'(e_stall));
    chk("md_bubble",   32'(md_bubble),   32'(e_stall));
    chk("md_wb_valid", 32'(md_wb_valid), 32'(e_valid));
    chk("md_wb_data",  md_wb_data,       e_data);
    chk("md_wb_rd",    32'(md_wb_rd),    32'(e_rd));
    chk("md_cycles",   32'(md_cycles),   32'(m_cyc));
  endtask

  task automatic tick();
    @(negedge clock);
    compare_all();
    s_stall = stall; s_mult = ctrl_MULT; s_div = ctrl_DIV; s_valid = md_wb_valid;
    s_data = md_wb_data; s_rd = md_wb_rd; s_cyc = md_cycles;
    @(posedge clock);
    if (reset_n) model_step();
    cyc_no++;
    #1;
  endtask

  task automatic idle_inputs();
    DX_valid = 0; flush = 0; md_result_rdy = 0; md_exception = 0;
    md_result = '0; DX_Latch_Instr = '0;
  endtask

  // One op from IDLE; k counts cycles from detect (k=0), so BUSY cycle n is k=n+1.
  task automatic run_op(input logic [31:0] instr, input int n_busy, input logic [31:0] res,
                        input logic exc, input int flush_at, input int n_cycles,
                        output int stall_cnt, output int mult_cnt, output int div_cnt,
                        output int valid_cnt, output logic [31:0] d, output logic [4:0] r,
                        output logic [5:0] c, output logic stall_after_flush);
    stall_cnt = 0; mult_cnt = 0; div_cnt = 0; valid_cnt = 0;
    d = '0; r = '0; c = '0; stall_after_flush = 1'bx;
    DX_Latch_Instr = instr; DX_valid = 1;
    for (int k = 0; k < n_cycles; k++) begin
      md_result_rdy = (k == n_busy + 1);
      md_result     = res;
      md_exception  = exc;
      flush         = (k == flush_at + 1);
      tick();
      if (s_stall) stall_cnt++;
      if (s_mult) mult_cnt++;
      if (s_div) div_cnt++;
      if (s_valid) begin valid_cnt++; d = s_data; r = s_rd; c = s_cyc; DX_valid = 0; end
      if (flush) DX_valid = 0;
      if (k == flush_at + 2) stall_after_flush = s_stall;
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int sc, mc, dc, vc;
    logic [31:0] d;
    logic [4:0]  r;
    logic [5:0]  c;
    logic        saf;
    int first_done, second_start, n_valid, op_idx;

    idle_inputs();
    reset_n = 0;
    #1;
    chk("reset_stall", 32'(stall), 0);
    chk("reset_wb_valid", 32'(md_wb_valid), 0);
    chk("reset_cycles", 32'(md_cycles), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    tick();

    // mul r3,r1,r2 with result after 32 BUSY cycles
    run_op(MUL_R3, 32, 32'h2A, 0, -10, 40, sc, mc, dc, vc, d, r, c, saf);
    chk("mul_stall_cycles", sc, 34);
    chk("mul_mult_pulses", mc, 1);
    chk("mul_div_pulses", dc, 0);
    chk("mul_wb_count", vc, 1);
    chk("mul_wb_rd", 32'(r), 3);
    chk("mul_wb_data", d, 32'h2A);
    chk("mul_cycles", 32'(c), 32);

    // div r4,r5,r6 with exception
    run_op(DIV_R4, 7, 32'hDEAD_BEEF, 1, -10, 15, sc, mc, dc, vc, d, r, c, saf);
    chk("div_div_pulses", dc, 1);
    chk("div_mult_pulses", mc, 0);
    chk("div_wb_rd", 32'(r), 30);
    chk("div_wb_data", d, 5);
    chk("div_cycles", 32'(c), 7);

    // rd==0 still produces a writeback
    run_op(32'h0000_0018, 2, 32'h1234, 0, -10, 10, sc, mc, dc, vc, d, r, c, saf);
    chk("rd0_wb_count", vc, 1);
    chk("rd0_wb_rd", 32'(r), 0);
    chk("rd0_wb_data", d, 32'h1234);

    // flush in BUSY cycle 5, stale rdy at cycle 32
    run_op(MUL_R3, 32, 32'h77, 0, 5, 40, sc, mc, dc, vc, d, r, c, saf);
    chk("flush_wb_count", vc, 0);
    chk("flush_stall_cycles", sc, 7);
    chk("flush_stall_after", 32'(saf), 0);

    // flush on the detect cycle suppresses the start
    run_op(MUL_R3, 3, 32'h1, 0, -1, 8, sc, mc, dc, vc, d, r, c, saf);
    chk("flush_idle_pulses", mc, 0);
    chk("flush_idle_wb", vc, 0);

    // mul then div back-to-back
    first_done = -1; second_start = -1; n_valid = 0; op_idx = 0;
    DX_Latch_Instr = MUL_R3; DX_valid = 1;
    for (int k = 0; k < 30 && n_valid < 2; k++) begin
      md_result_rdy = m_active && !m_done && (m_pos - 1 == (op_idx == 0 ? 3 : 4));
      md_result = (op_idx == 0) ? 32'h11 : 32'h22;
      md_exception = 0;
      tick();
      if (s_div && second_start < 0) second_start = k;
      if (s_valid) begin
        n_valid++;
        if (first_done < 0) first_done = k;
        op_idx++;
        DX_Latch_Instr = DIV_R4;
        if (op_idx == 2) DX_valid = 0;
      end
    end
    idle_inputs();
    chk("b2b_wb_count", n_valid, 2);
    chk("b2b_start_gap", second_start - first_done, 2);
    tick();

    // asynchronous reset mid-BUSY
    DX_Latch_Instr = MUL_R3; DX_valid = 1;
    repeat (12) tick();
    #2;
    DX_valid = 0;
    reset_n = 0;
    #1;
    chk("areset_stall", 32'(stall), 0);
    chk("areset_bubble", 32'(md_bubble), 0);
    chk("areset_wb_valid", 32'(md_wb_valid), 0);
    chk("areset_cycles", 32'(md_cycles), 0);
    chk("areset_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 0);
    model_reset();
    tick();
    reset_n = 1;
    md_result_rdy = 1; md_result = 32'h99;
    tick();
    md_result_rdy = 0;
    vc = 0;
    repeat (5) begin tick(); if (s_valid) vc++; end
    chk("areset_stale_rdy_wb", vc, 0);

    // no rdy for a mul: watchdog fires or the unit waits
    run_op(MUL_R3, 9999, 32'h0, 0, -10, 70, sc, mc, dc, vc, d, r, c, saf);
`ifdef MD_WATCHDOG_EN
    chk("wd_wb_count", vc, 1);
    chk("wd_wb_rd", 32'(r), 30);
    chk("wd_wb_data", d, 4);
    chk("wd_cycles", 32'(c), 48);
    chk("wd_stall_cycles", sc, 50);
`else
    chk("nowd_wb_count", vc, 0);
    chk("nowd_stall_cycles", sc, 70);
    chk("nowd_cycles_sat", 32'(md_cycles), 63);
`endif
    flush = 1;
    tick();
    idle_inputs();
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      DX_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: DX_Latch_Instr = mk_instr(5'($urandom), 5'd6);
        1: DX_Latch_Instr = mk_instr(5'($urandom), 5'd7);
        2: DX_Latch_Instr = mk_instr(5'($urandom), 5'($urandom));
        default: DX_Latch_Instr = $urandom;
      endcase
      flush = ($urandom_range(0, 19) == 0);
      if (m_active && !m_done && m_pos >= 2) md_result_rdy = ($urandom_range(0, 5) == 0);
      else md_result_rdy = ($urandom_range(0, 9) == 0);
      md_exception = ($urandom_range(0, 3) == 0);
      md_result = $urandom;
      tick();
    end
    idle_inputs();
    flush = 1;
    tick();
    idle_inputs();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
